// File: rtl/anti_noise_i2s_tx.sv
// I2S transmitter for the anti-noise path: rounds/saturates 32-bit LMS output to 16 bits,
// buffers it in a small FIFO and serializes it as mono (L=R) I2S with internally derived bclk/lrclk.
module anti_noise_i2s_tx #(
    parameter int FRAC_SHIFT = 15,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_sample,
    input  logic        enable,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        sat,
    output logic        overflow,
    output logic        underflow
);

    // state | meaning
    // IDLE  | serializer stopped, outputs low, counters at reset values
    // RUN   | bclk running, one 32-slot frame per FIFO word
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic signed [32:0] ROUND  = 33'sd1 <<< (FRAC_SHIFT - 1);

    logic signed [32:0] conv_sum;
    logic signed [32:0] conv_shift;
    logic [15:0]        conv_next;
    logic               conv_clip;
    logic               conv_valid;
    logic [15:0]        conv_word;

    always_comb begin
        conv_sum   = $signed({in_sample[31], in_sample}) + ROUND;
        conv_shift = conv_sum >>> FRAC_SHIFT;
        conv_next  = conv_shift[15:0];
        conv_clip  = 1'b0;
        if (conv_shift > 33'sd32767) begin
            conv_next = 16'h7FFF;
            conv_clip = 1'b1;
        end else if (conv_shift < -33'sd32768) begin
            conv_next = 16'h8000;
            conv_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_valid <= 1'b0;
            conv_word  <= 16'h0000;
            sat        <= 1'b0;
        end else begin
            conv_valid <= in_valid;
            conv_word  <= conv_next;
            sat        <= in_valid & conv_clip;
        end
    end

    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             pop_req;
    logic             pop;
    logic             push;
    logic [15:0]      rd_word;

    logic [0:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [4:0]       bit_nxt;
    logic [31:0]      shift_reg;
    logic             div_last;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign div_last = (div_cnt == DIV_LAST);
    assign bit_nxt  = bit_cnt + 5'd1;
    // The pop coincides with the bclk fall that moves slot 0 -> slot 1.
    assign pop_req  = (state == ST_RUN) & enable & div_last & bclk & (bit_cnt == 5'd0);
    assign pop      = pop_req & ~empty;
    assign push     = conv_valid & (~full | pop);
    assign rd_word  = empty ? 16'h0000 : mem[rd_ptr];

    assign overflow  = conv_valid & full & ~pop;
    assign underflow = pop_req & empty;
    assign sdata     = shift_reg[31];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= conv_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            bit_cnt   <= 5'd31;
            shift_reg <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    div_cnt   <= '0;
                    bclk      <= 1'b0;
                    lrclk     <= 1'b0;
                    bit_cnt   <= 5'd31;
                    shift_reg <= 32'h0;
                    if (enable) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (!enable) begin
                        state     <= ST_IDLE;
                        div_cnt   <= '0;
                        bclk      <= 1'b0;
                        lrclk     <= 1'b0;
                        bit_cnt   <= 5'd31;
                        shift_reg <= 32'h0;
                    end else if (div_last) begin
                        div_cnt <= '0;
                        bclk    <= ~bclk;
                        if (bclk) begin
                            bit_cnt <= bit_nxt;
                            lrclk   <= bit_nxt[4];
                            if (bit_nxt == 5'd1) begin
                                shift_reg <= {rd_word, rd_word};
                            end else begin
                                shift_reg <= {shift_reg[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anti_noise_i2s_tx.sv
// Bench for anti_noise_i2s_tx: a cycle-count based model of the I2S frame and FIFO checks every
// output each cycle; a bclk-rise decoder and pulse counters pin the model with literal values.
module tb_anti_noise_i2s_tx;
    localparam int FS    = 15;
    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_sample = 32'h0;
    logic        enable = 1'b0;
    logic        bclk, lrclk, sdata, sat, overflow, underflow;

    anti_noise_i2s_tx #(.FRAC_SHIFT(FS), .BCLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample), .enable(enable),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .sat(sat), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame position derived from cycles elapsed since entering RUN.
    bit          m_run;
    int          m_n;
    bit          m_cv;
    logic [15:0] m_cw;
    bit          m_cs;
    logic [15:0] q[$];
    logic [15:0] m_fw;
    bit          m_fv;

    function automatic void convert(input logic [31:0] x, output logic [15:0] w, output bit s);
        longint v;
        v = longint'($signed(x)) + (longint'(1) <<< (FS - 1));
        v = v >>> FS;
        if (v > 32767) begin
            w = 16'h7FFF; s = 1'b1;
        end else if (v < -32768) begin
            w = 16'h8000; s = 1'b1;
        end else begin
            w = v[15:0]; s = 1'b0;
        end
    endfunction

    function automatic bit pop_now();
        return m_run && enable && (((m_n + 1) % (64 * D)) == 4 * D);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_n = 0; m_cv = 0; m_cw = 0; m_cs = 0;
            q.delete(); m_fw = 0; m_fv = 0;
        end else begin
            bit          p;
            logic [15:0] w;
            bit          s;
            p = pop_now();
            if (p) begin
                if (q.size() > 0) m_fw = q.pop_front();
                else m_fw = 16'h0;
                m_fv = 1;
            end
            if (m_cv && q.size() < DEPTH) q.push_back(m_cw);
            convert(in_sample, w, s);
            m_cv = in_valid;
            m_cw = w;
            m_cs = s && in_valid;
            if (!m_run) begin
                if (enable) begin m_run = 1; m_n = 0; m_fv = 0; end
            end else if (!enable) begin
                m_run = 0;
            end else begin
                m_n++;
            end
        end
    end

    int cnt_sat, cnt_ov, cnt_uf;

    always @(negedge clk) begin
        int   k, slot;
        bit   v;
        logic e_bclk, e_lr, e_sd, e_ov, e_uf, e_sat;
        e_bclk = m_run ? (((m_n / D) % 2) == 1) : 1'b0;
        k      = m_n / (2 * D);
        v      = m_run && k >= 1;
        slot   = (k - 1) % 32;
        e_lr   = v && slot >= 16;
        if (!v)              e_sd = 1'b0;
        else if (slot == 0)  e_sd = m_fv ? m_fw[0] : 1'b0;
        else if (slot <= 16) e_sd = m_fw[16 - slot];
        else                 e_sd = m_fw[32 - slot];
        e_uf  = pop_now() && q.size() == 0;
        e_ov  = m_cv && q.size() == DEPTH && !pop_now();
        e_sat = m_cv && m_cs;
        check("bclk", 32'(bclk), 32'(e_bclk));
        check("lrclk", 32'(lrclk), 32'(e_lr));
        check("sdata", 32'(sdata), 32'(e_sd));
        check("sat", 32'(sat), 32'(e_sat));
        check("overflow", 32'(overflow), 32'(e_ov));
        check("underflow", 32'(underflow), 32'(e_uf));
        cnt_sat += int'(sat === 1'b1);
        cnt_ov  += int'(overflow === 1'b1);
        cnt_uf  += int'(underflow === 1'b1);
    end

    // Receiver: on the bclk rise of slot 0 the previous 32 slots hold {left, right}.
    logic [31:0] dec = 32'h0;
    bit          prev_lr = 0;
    logic [31:0] words[$];

    always @(posedge bclk) begin
        dec = {dec[30:0], sdata};
        if (prev_lr && !lrclk) words.push_back(dec);
        prev_lr = lrclk;
    end

    task automatic clear_obs();
        words.delete();
        prev_lr = 0;
        cnt_sat = 0; cnt_ov = 0; cnt_uf = 0;
    endtask

    task automatic run(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] x);
        in_valid = 1'b1;
        in_sample = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic strobe_word(input logic [15:0] w);
        strobe({w[15], w, 15'h0});
    endtask

    task automatic check_words(input string name, input logic [15:0] exp[$]);
        check({name, "_count"}, 32'(words.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < words.size()) check(name, words[i], {exp[i], exp[i]});
        end
    endtask

    initial begin
        clear_obs();
        run(3);
        check("reset_outputs", 32'({bclk, lrclk, sdata, sat, overflow, underflow}), 32'h0);
        rst_n = 1'b1;
        run(2);

        // Conversion vectors into an idle FIFO; the fifth write overflows.
        clear_obs();
        strobe(32'h00008000);
        strobe(32'h40000000);
        strobe(32'hFFFFC000);
        strobe(32'hFFFFBFFF);
        strobe(32'h80000000);
        run(2);
        check("conv_sat_count", 32'(cnt_sat), 32'd2);
        check("conv_ov_count", 32'(cnt_ov), 32'd1);
        enable = 1'b1;
        run(1300);
        check_words("conv_words", '{16'h0001, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0000});
        check("conv_uf_count", 32'(cnt_uf), 32'd2);
        enable = 1'b0;
        run(5);

        // Framing with three words, then underflow frames.
        clear_obs();
        strobe_word(16'h1234);
        strobe_word(16'hA5C3);
        strobe_word(16'h0001);
        run(2);
        enable = 1'b1;
        run(1044);
        check_words("frame_words", '{16'h1234, 16'hA5C3, 16'h0001, 16'h0000});
        check("frame_uf_count", 32'(cnt_uf), 32'd2);
        check("frame_ov_count", 32'(cnt_ov), 32'd0);
        enable = 1'b0;
        run(5);

        // Push lands on the slot-1 pop edge while the FIFO is full.
        clear_obs();
        strobe_word(16'h0011);
        strobe_word(16'h0022);
        strobe_word(16'h0033);
        strobe_word(16'h0044);
        run(2);
        enable = 1'b1;
        run(1);
        run(14);
        strobe_word(16'h0055);
        run(1290);
        check("collide_ov_count", 32'(cnt_ov), 32'd0);
        check_words("collide_words", '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055});
        check("collide_uf_count", 32'(cnt_uf), 32'd1);
        enable = 1'b0;
        run(5);

        // Disruption: drop enable mid-left-slot, re-enable, then async reset mid-frame.
        clear_obs();
        enable = 1'b1;
        run(100);
        enable = 1'b0;
        run(1);
        check("disable_outputs", 32'({bclk, lrclk, sdata}), 32'h0);
        run(10);
        enable = 1'b1;
        run(300);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({bclk, lrclk, sdata, sat, overflow, underflow}), 32'h0);
        @(posedge clk);
        #1;
        run(2);
        rst_n = 1'b1;
        clear_obs();
        run(300);
        check_words("post_reset_words", '{16'h0000});
        check("post_reset_uf_count", 32'(cnt_uf), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
